// File: rtl/apb_pkg.sv
// Shared definitions for the APB command bridge.
// Contents:
//   apb_state_e      bridge FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   APB_ADDR_W       default address width
//   APB_DATA_W       default data width
//   APB_TIMEOUT_CYC  default ACCESS-phase timeout in cycles (0 disables it)
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } apb_state_e;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_cmd_bridge_if.sv
// Bundle of the command, response and APB requester signals of apb_cmd_bridge.
// Modports:
//   master  bridge side: takes commands, drives APB, returns responses
//   slave   environment side: issues commands, models the APB fabric,
//           consumes responses
interface apb_cmd_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-cycle counter for the ACCESS phase.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous reset, active-high
//   clr     zero the counter (takes priority over en)
//   en      count one more wait cycle
//   expire  count has reached TIMEOUT_CYC-1; never set when TIMEOUT_CYC=0
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // A zero timeout still needs a legal 1-bit counter.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  logic [CNT_W-1:0] count_r;

  // Wait counter: clear wins, otherwise count up and hold at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && (count_r == CNT_LAST);

endmodule

// File: rtl/apb_cmd_bridge.sv
// Command-to-APB requester bridge: accepts one read/write command, runs an
// APB SETUP->ACCESS transfer and holds a single response until consumed.
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous reset, active-high; aborts any transfer in flight
//   bus     apb_cmd_bridge_if.master: cmd_* in, rsp_* out, APB requester side
// All bus outputs come straight from registers.
module apb_cmd_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_cmd_bridge_if.master bus
);

  apb_state_e        state_r, state_next;
  logic              cmd_ready_r, cmd_ready_next;
  logic              psel_r, psel_next;
  logic              penable_r, penable_next;
  logic              pwrite_r, pwrite_next;
  logic [ADDR_W-1:0] paddr_r, paddr_next;
  logic [DATA_W-1:0] pwdata_r, pwdata_next;
  logic              rsp_valid_r, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_next;
  logic              rsp_err_r, rsp_err_next;
  logic              rsp_timeout_r, rsp_timeout_next;
  logic              tmr_clr_s, tmr_en_s, tmr_expire_s;

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (tmr_clr_s),
    .en     (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next       = state_r;
    cmd_ready_next   = cmd_ready_r;
    psel_next        = psel_r;
    penable_next     = penable_r;
    pwrite_next      = pwrite_r;
    paddr_next       = paddr_r;
    pwdata_next      = pwdata_r;
    rsp_valid_next   = rsp_valid_r;
    rsp_rdata_next   = rsp_rdata_r;
    rsp_err_next     = rsp_err_r;
    rsp_timeout_next = rsp_timeout_r;
    tmr_clr_s        = 1'b0;
    tmr_en_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_next     = ST_SETUP;
          cmd_ready_next = 1'b0;
          psel_next      = 1'b1;
          penable_next   = 1'b0;
          pwrite_next    = bus.cmd_write;
          paddr_next     = bus.cmd_addr;
          pwdata_next    = bus.cmd_wdata;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // Counter is zero in the first ACCESS cycle.
        state_next   = ST_ACCESS;
        penable_next = 1'b1;
        tmr_clr_s    = 1'b1;
      end
      ST_ACCESS: begin
        // A ready slave wins over a timeout expiring in the same cycle.
        if (bus.PREADY) begin
          state_next       = ST_RESP;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = pwrite_r ? {DATA_W{1'b0}} : bus.PRDATA;
          rsp_err_next     = bus.PSLVERR;
          rsp_timeout_next = 1'b0;
        end else if (tmr_expire_s) begin
          state_next       = ST_RESP;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = {DATA_W{1'b0}};
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_RESP: begin
        // No bypass: a new command is taken only once back in IDLE.
        if (bus.rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        cmd_ready_next = 1'b1;
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r       <= ST_IDLE;
      cmd_ready_r   <= 1'b1;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next;
      cmd_ready_r   <= cmd_ready_next;
      psel_r        <= psel_next;
      penable_r     <= penable_next;
      pwrite_r      <= pwrite_next;
      paddr_r       <= paddr_next;
      pwdata_r      <= pwdata_next;
      rsp_valid_r   <= rsp_valid_next;
      rsp_rdata_r   <= rsp_rdata_next;
      rsp_err_r     <= rsp_err_next;
      rsp_timeout_r <= rsp_timeout_next;
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.PSEL        = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule
